// File: rtl/fin_conditioner.sv
// Input conditioner for the frequency meter: synchroniser, pulse-width filter, rising-edge pulse and loss-of-signal watchdog.
// Define FIN_GLITCH_CNT_EN to build the saturating rejected-pulse counter; otherwise glitch_cnt reads 0.
module fin_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int FILT_W      = 4,
    parameter int TIMEOUT     = 10000000,
    parameter int TMO_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       F_in,
    input  logic       glitch_clr,
    output logic       f_clean,
    output logic       f_pulse,
    output logic       no_signal,
    output logic [7:0] glitch_cnt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   f_clean_q, f_clean_d;
    logic [FILT_W-1:0]      fc_q, fc_d;
    logic                   f_pulse_q, f_pulse_d;
    logic                   no_signal_q, no_signal_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   rise;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], F_in};
        f_clean_d   = f_clean_q;
        fc_d        = '0;
        rise        = 1'b0;
        if (s != f_clean_q) begin
            if (fc_q == FILT_W'(FILT_LEN - 1)) begin
                f_clean_d = s;
                rise      = s;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
        f_pulse_d   = rise;
        // Watchdog restarts on the same edge that raises f_pulse.
        tmo_d       = tmo_q;
        no_signal_d = no_signal_q;
        if (rise) begin
            tmo_d       = '0;
            no_signal_d = 1'b0;
        end else if (tmo_q != TMO_W'(TIMEOUT - 1)) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            no_signal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            f_clean_q   <= 1'b0;
            fc_q        <= '0;
            f_pulse_q   <= 1'b0;
            no_signal_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            f_clean_q   <= f_clean_d;
            fc_q        <= fc_d;
            f_pulse_q   <= f_pulse_d;
            no_signal_q <= no_signal_d;
            tmo_q       <= tmo_d;
        end
    end

    assign f_clean   = f_clean_q;
    assign f_pulse   = f_pulse_q;
    assign no_signal = no_signal_q;

`ifdef FIN_GLITCH_CNT_EN
    logic [7:0] gcnt_q, gcnt_d;
    logic       reject;

    // A rejection is the synchronised level reverting while a change was still qualifying.
    always_comb begin
        reject = (s == f_clean_q) && (fc_q != '0);
        gcnt_d = gcnt_q;
        if (glitch_clr) begin
            gcnt_d = '0;
        end else if (reject && (gcnt_q != 8'hFF)) begin
            gcnt_d = gcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt = gcnt_q;
`else
    logic unused_glitch_clr;

    assign unused_glitch_clr = glitch_clr;
    assign glitch_cnt        = '0;
`endif

endmodule

// File: tb/tb_fin_conditioner.sv
// Directed self-checking bench for fin_conditioner (SYNC_STAGES=2, FILT_LEN=3, TIMEOUT=20).
module tb_fin_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       F_in = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       f_clean;
    logic       f_pulse;
    logic       no_signal;
    logic [7:0] glitch_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FIN_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    fin_conditioner #(
        .SYNC_STAGES(2),
        .FILT_LEN   (3),
        .FILT_W     (4),
        .TIMEOUT    (20),
        .TMO_W      (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .F_in      (F_in),
        .glitch_clr(glitch_clr),
        .f_clean   (f_clean),
        .f_pulse   (f_pulse),
        .no_signal (no_signal),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic sq(input int m);
        return (m >= 0) && ((m % 8) < 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] exp_v;
        rst  = 1'b1;
        F_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            exp_v = {1'b0, 1'b0, (i >= 20), 8'd0};
            n_cmp++;
            if ({f_clean, f_pulse, no_signal, glitch_cnt} !== exp_v) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i,
                         {f_clean, f_pulse, no_signal, glitch_cnt}, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_step();
        F_in = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            n_cmp++;
            if ({f_clean, f_pulse, no_signal} !== {(j >= 5), (j == 5), (j < 5)}) begin
                n_err++;
                $display("FAIL step_rise j=%0d got=%b exp=%b", j, {f_clean, f_pulse, no_signal},
                         {(j >= 5), (j == 5), (j < 5)});
            end
        end
        F_in = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_cmp++;
            if ({f_clean, f_pulse} !== {(j < 5), 1'b0}) begin
                n_err++;
                $display("FAIL step_fall j=%0d got=%b exp=%b", j, {f_clean, f_pulse}, {(j < 5), 1'b0});
            end
        end
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 10; g++) begin
            for (int c = 0; c < 6; c++) begin
                F_in = (c < 2);
                tick();
                n_cmp++;
                if ({f_clean, f_pulse} !== 2'b00) begin
                    n_err++;
                    $display("FAIL glitch_pass g=%0d c=%0d got=%b exp=00", g, c, {f_clean, f_pulse});
                end
            end
        end
        n_cmp++;
        if (glitch_cnt !== (GC_EN ? 8'd10 : 8'd0)) begin
            n_err++;
            $display("FAIL glitch_cnt10 got=%0d exp=%0d", glitch_cnt, GC_EN ? 10 : 0);
        end
    endtask

    task automatic test_saturate();
        for (int g = 0; g < 300; g++) begin
            for (int c = 0; c < 6; c++) begin
                F_in = (c < 2);
                tick();
            end
        end
        n_cmp++;
        if (glitch_cnt !== (GC_EN ? 8'd255 : 8'd0)) begin
            n_err++;
            $display("FAIL glitch_sat got=%0d exp=%0d", glitch_cnt, GC_EN ? 255 : 0);
        end
        // Clear pulse lands exactly on the rejection edge of this glitch.
        for (int c = 0; c < 6; c++) begin
            F_in       = (c < 2);
            glitch_clr = (c == 4);
            if (c == 4) begin
                n_cmp++;
                if (glitch_cnt !== (GC_EN ? 8'd255 : 8'd0)) begin
                    n_err++;
                    $display("FAIL glitch_preclr got=%0d exp=%0d", glitch_cnt, GC_EN ? 255 : 0);
                end
            end
            tick();
            if (c == 4) begin
                n_cmp++;
                if (glitch_cnt !== 8'd0) begin
                    n_err++;
                    $display("FAIL glitch_clr_wins got=%0d exp=0", glitch_cnt);
                end
            end
        end
        glitch_clr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            F_in = (c < 2);
            tick();
        end
        n_cmp++;
        if (glitch_cnt !== (GC_EN ? 8'd1 : 8'd0)) begin
            n_err++;
            $display("FAIL glitch_resume got=%0d exp=%0d", glitch_cnt, GC_EN ? 1 : 0);
        end
    endtask

    task automatic test_square();
        int pulses = 0;
        for (int m = 0; m < 200; m++) begin
            int j;
            F_in = sq(m);
            tick();
            j = m + 1;
            if (f_pulse === 1'b1) pulses++;
            n_cmp++;
            if (f_clean !== sq(j - 5)) begin
                n_err++;
                $display("FAIL square_clean j=%0d got=%b exp=%b", j, f_clean, sq(j - 5));
            end
            n_cmp++;
            if (f_pulse !== (sq(j - 5) && !sq(j - 6))) begin
                n_err++;
                $display("FAIL square_pulse j=%0d got=%b exp=%b", j, f_pulse, sq(j - 5) && !sq(j - 6));
            end
            if (j >= 5) begin
                n_cmp++;
                if (no_signal !== 1'b0) begin
                    n_err++;
                    $display("FAIL square_nosig j=%0d got=%b exp=0", j, no_signal);
                end
            end
        end
        n_cmp++;
        if (pulses != 25) begin
            n_err++;
            $display("FAIL square_pulse_count got=%0d exp=25", pulses);
        end
        F_in = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_midfilter();
        F_in = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({f_clean, f_pulse, no_signal, glitch_cnt} !== 11'd0) begin
            n_err++;
            $display("FAIL midrst_state got=%b exp=0", {f_clean, f_pulse, no_signal, glitch_cnt});
        end
        for (int j = 6; j <= 11; j++) begin
            tick();
            n_cmp++;
            if ({f_clean, f_pulse} !== {(j >= 10), (j == 10)}) begin
                n_err++;
                $display("FAIL midrst_requal j=%0d got=%b exp=%b", j, {f_clean, f_pulse},
                         {(j >= 10), (j == 10)});
            end
        end
        F_in = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_saturate();
        test_square();
        test_reset_midfilter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
